// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the store narrowing path: access-size codes (common
// with the load-extension unit), FSM state encodings and the alignment check.
package store_narrow_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // A store is rejected when its address is not naturally aligned for its
    // size, or when the size code is the reserved one.
    function automatic logic store_rejected(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_narrow_rmw_lane_merge.sv
// lane_merge: places the narrow store data into its little-endian byte lane(s).
// Produces the lane mask and either the old word with the addressed lanes
// replaced (REPLICATE=0) or the data replicated across all lanes (REPLICATE=1).
module lane_merge
    import store_narrow_rmw_pkg::*;
#(
    parameter bit REPLICATE = 1'b0
) (
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged,
    output logic [3:0]  mask
);

    logic [31:0] repl;
    logic [31:0] bit_mask;

    // Replicate the low data bits over every lane, pick the addressed lanes, then merge.
    always_comb begin
        repl     = data;
        mask     = 4'b1111;
        bit_mask = '0;
        case (size)
            SZ_BYTE: begin
                repl = {4{data[7:0]}};
                mask = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                repl = {2{data[15:0]}};
                mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                repl = data;
                mask = 4'b1111;
            end
        endcase
        for (int k = 0; k < 4; k++) begin
            bit_mask[8*k +: 8] = {8{mask[k]}};
        end
        merged = REPLICATE ? repl : ((old_word & ~bit_mask) | (repl & bit_mask));
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw: narrows a register value to byte/half/word and writes it
// into a word-wide data RAM at the addressed lane(s).
// Default build: read-modify-write (IDLE -> READ -> MERGE -> WRITE for byte/half).
// With MEM_BYTE_ENABLE_EN defined: single write using mem_be lane strobes and
// lane-replicated write data; no READ/MERGE states.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
`ifdef MEM_BYTE_ENABLE_EN
    output logic [3:0]        mem_be,
`endif
    output logic [31:0]       mem_wdata
);

    state_t      state;
    state_t      state_nxt;
    logic        req_bad;
    logic        accept;
    logic [31:0] merged;

    assign req_bad = store_rejected(req_size, req_addr[1:0]);
    assign accept  = (state == ST_IDLE) && req_valid;

`ifdef MEM_BYTE_ENABLE_EN
    logic [3:0] lane_mask;
    logic       rdata_unused;

    // Without read-back, the RAM data input is not needed.
    assign rdata_unused = ^mem_rdata;

    lane_merge #(.REPLICATE(1'b1)) u_lane_merge (
        .old_word (32'h0),
        .data     (req_data),
        .size     (req_size),
        .addr_lo  (req_addr[1:0]),
        .merged   (merged),
        .mask     (lane_mask)
    );
`else
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  mask_unused;

    lane_merge #(.REPLICATE(1'b0)) u_lane_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .addr_lo  (addr_lo_q),
        .merged   (merged),
        .mask     (mask_unused)
    );

    // Request fields kept for the merge step; only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q    <= req_data;
            size_q    <= req_size;
            addr_lo_q <= req_addr[1:0];
        end
    end
`endif

    // State register; reset aborts any store in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_nxt = ST_ERR;
`ifdef MEM_BYTE_ENABLE_EN
                    end else begin
                        state_nxt = ST_WRITE;
                    end
`else
                    end else if (req_size == SZ_WORD) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
`endif
                end
            end
`ifndef MEM_BYTE_ENABLE_EN
            ST_READ: begin
                mem_re    = 1'b1;
                state_nxt = ST_MERGE;
            end
            ST_MERGE: begin
                state_nxt = ST_WRITE;
            end
`endif
            ST_WRITE: begin
                mem_we    = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                done      = 1'b1;
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Memory address and write data: loaded at accept, merged data captured in MERGE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_BYTE_ENABLE_EN
            mem_be    <= '0;
`endif
        end else if (accept) begin
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
`ifdef MEM_BYTE_ENABLE_EN
            mem_wdata <= merged;
            mem_be    <= lane_mask;
`else
            mem_wdata <= req_data;
        end else if (state == ST_MERGE) begin
            mem_wdata <= merged;
`endif
        end
    end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: word-RAM model, table of directed stores with
// hand-computed results, plus a reset-abort sequence for the RMW build.
module tb_store_narrow_rmw;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
`ifdef MEM_BYTE_ENABLE_EN
    logic [3:0]  mem_be;
`endif

    store_narrow_rmw #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
`ifdef MEM_BYTE_ENABLE_EN
        .mem_be    (mem_be),
`endif
        .mem_wdata (mem_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model
    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    int          re_cnt;
    int          we_cnt;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_we) begin
`ifdef MEM_BYTE_ENABLE_EN
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) mem[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
`else
            mem[mem_addr[9:2]] <= mem_wdata;
`endif
        end
        if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    int errors;
    int checks;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = addr[9:2];
        pl_data = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] old;
        logic        exp_err;
        logic [31:0] exp_mem;
        logic [31:0] exp_wd_be;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[11];

    task automatic run_store(input int idx, input vec_t v);
        int          lat;
        int          exp_lat;
        int          exp_re;
        int          re0;
        int          we0;
        logic        got;
        logic        busy_ready;
        logic        d_err;
        logic        d_we;
        logic [31:0] d_wd;
        logic [31:0] d_addr;
        logic [3:0]  d_be;
        string       tag;
        tag = $sformatf("v%0d", idx);
        exp_lat = 1;
        exp_re  = 0;
`ifndef MEM_BYTE_ENABLE_EN
        if (!v.exp_err && v.size != 2'b10) begin
            exp_lat = 3;
            exp_re  = 1;
        end
`endif
        preload(v.addr, v.old);
        @(negedge clk);
        chk({tag, "_ready_idle"}, req_ready, 1);
        re0 = re_cnt;
        we0 = we_cnt;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        req_size  = v.size;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_data  = 32'h0;
        req_size  = 2'b10;
        lat = 0;
        got = 1'b0;
        busy_ready = 1'b0;
        d_err = 1'b0; d_we = 1'b0; d_wd = '0; d_addr = '0; d_be = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (req_ready) busy_ready = 1'b1;
            if (done) begin
                got    = 1'b1;
                d_err  = err;
                d_we   = mem_we;
                d_wd   = mem_wdata;
                d_addr = mem_addr;
`ifdef MEM_BYTE_ENABLE_EN
                d_be   = mem_be;
`endif
            end
        end
        chk({tag, "_done_seen"}, got, 1);
        if (got) begin
            chk({tag, "_latency"}, lat, exp_lat);
            chk({tag, "_err"}, d_err, v.exp_err);
            chk({tag, "_we_at_done"}, d_we, !v.exp_err);
            chk({tag, "_ready_busy"}, busy_ready, 0);
            if (!v.exp_err) begin
                chk({tag, "_mem_addr"}, d_addr, {v.addr[31:2], 2'b00});
`ifdef MEM_BYTE_ENABLE_EN
                chk({tag, "_wdata"}, d_wd, v.exp_wd_be);
                chk({tag, "_be"}, d_be, v.exp_be);
`else
                chk({tag, "_wdata"}, d_wd, v.exp_mem);
`endif
            end
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_re_count"}, re_cnt - re0, exp_re);
            chk({tag, "_we_count"}, we_cnt - we0, v.exp_err ? 0 : 1);
            chk({tag, "_mem"}, mem[v.addr[9:2]], v.exp_mem);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        re_cnt = 0;
        we_cnt = 0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;

        vecs[0]  = '{32'h100, 32'hDEADBEEF, 2'b10, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111};
        vecs[1]  = '{32'h106, 32'hFFFFFFAB, 2'b00, 32'h11223344, 1'b0, 32'h11AB3344, 32'hABABABAB, 4'b0100};
        vecs[2]  = '{32'h10A, 32'hABCD1234, 2'b01, 32'hCAFEF00D, 1'b0, 32'h1234F00D, 32'h12341234, 4'b1100};
        vecs[3]  = '{32'h108, 32'hABCD1234, 2'b01, 32'hCAFEF00D, 1'b0, 32'hCAFE1234, 32'h12341234, 4'b0011};
        vecs[4]  = '{32'h10C, 32'h00000077, 2'b00, 32'hAABBCCDD, 1'b0, 32'hAABBCC77, 32'h77777777, 4'b0001};
        vecs[5]  = '{32'h10F, 32'h00000099, 2'b00, 32'hAABBCCDD, 1'b0, 32'h99BBCCDD, 32'h99999999, 4'b1000};
        vecs[6]  = '{32'h203, 32'h0000005A, 2'b00, 32'h01020304, 1'b0, 32'h5A020304, 32'h5A5A5A5A, 4'b1000};
        vecs[7]  = '{32'h101, 32'h00001234, 2'b01, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 32'h0, 4'b0000};
        vecs[8]  = '{32'h102, 32'h12345678, 2'b10, 32'h13572468, 1'b1, 32'h13572468, 32'h0, 4'b0000};
        vecs[9]  = '{32'h110, 32'h12345678, 2'b11, 32'h24681357, 1'b1, 32'h24681357, 32'h0, 4'b0000};
        vecs[10] = '{32'h113, 32'h00005555, 2'b01, 32'h11111111, 1'b1, 32'h11111111, 32'h0, 4'b0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
`ifdef MEM_BYTE_ENABLE_EN
        chk("rst_mem_be", mem_be, 4'b0000);
`endif
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_store(i, vecs[i]);
        end

`ifndef MEM_BYTE_ENABLE_EN
        // Reset during MERGE of a byte store must cancel the write.
        begin
            int we0;
            preload(32'h114, 32'h55667788);
            @(negedge clk);
            we0 = we_cnt;
            req_valid = 1'b1; req_addr = 32'h115; req_data = 32'hEE; req_size = 2'b00;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            chk("abort_read_strobe", mem_re, 1);
            @(negedge clk);
            chk("abort_in_merge_not_ready", req_ready, 0);
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("abort_ready", req_ready, 1);
            chk("abort_no_we", mem_we, 0);
            chk("abort_no_done", done, 0);
            chk("abort_wdata_cleared", mem_wdata, 32'h0);
            repeat (3) @(negedge clk);
            chk("abort_we_count", we_cnt - we0, 0);
            chk("abort_mem", mem[8'h45], 32'h55667788);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
